// File: rtl/e20_state_dumper.sv
// Post-halt state unloader for the E20 core: on a rising halt, streams the PC, the eight
// registers and the first DUMP_WORDS memory words as tagged items over valid/ready.
module e20_state_dumper #(
    parameter int unsigned ADDR_W     = 13,
    parameter int unsigned DUMP_WORDS = 128
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              halt_i,
    input  logic [15:0]       pc_i,
    output logic [2:0]        reg_rd_addr_o,
    input  logic [15:0]       reg_rd_data_i,
    output logic              mem_rd_en_o,
    output logic [ADDR_W-1:0] mem_rd_addr_o,
    input  logic [15:0]       mem_rd_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [1:0]        out_kind_o,
    output logic [15:0]       out_addr_o,
    output logic [15:0]       out_data_o,
    output logic              out_last_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [1:0] KindPc  = 2'd0;
    localparam logic [1:0] KindReg = 2'd1;
    localparam logic [1:0] KindMem = 2'd2;
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DUMP_WORDS - 1);

    typedef enum logic [1:0] {StIdle, StSend, StWait, StDone} state_e;

    state_e              state_q, state_d;
    logic                halt_q;
    logic [1:0]          out_kind_q, out_kind_d;
    logic [15:0]         out_addr_q, out_addr_d;
    logic [15:0]         out_data_q, out_data_d;
    logic                out_last_q, out_last_d;
    logic [2:0]          reg_rd_addr_q, reg_rd_addr_d;
    logic [ADDR_W-1:0]   mem_rd_addr_q, mem_rd_addr_d;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q       <= StIdle;
            halt_q        <= 1'b0;
            out_kind_q    <= '0;
            out_addr_q    <= '0;
            out_data_q    <= '0;
            out_last_q    <= 1'b0;
            reg_rd_addr_q <= '0;
            mem_rd_addr_q <= '0;
        end else begin
            state_q       <= state_d;
            halt_q        <= halt_i;
            out_kind_q    <= out_kind_d;
            out_addr_q    <= out_addr_d;
            out_data_q    <= out_data_d;
            out_last_q    <= out_last_d;
            reg_rd_addr_q <= reg_rd_addr_d;
            mem_rd_addr_q <= mem_rd_addr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        out_kind_d    = out_kind_q;
        out_addr_d    = out_addr_q;
        out_data_d    = out_data_q;
        out_last_d    = out_last_q;
        reg_rd_addr_d = reg_rd_addr_q;
        mem_rd_addr_d = mem_rd_addr_q;
        mem_rd_en_o   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (halt_i && !halt_q) begin
                    out_data_d    = pc_i;
                    out_kind_d    = KindPc;
                    out_addr_d    = '0;
                    out_last_d    = 1'b0;
                    reg_rd_addr_d = '0;
                    mem_rd_addr_d = '0;
                    state_d       = StSend;
                end
            end
            StSend: begin
                if (out_ready_i) begin
                    if (out_kind_q == KindPc || (out_kind_q == KindReg && out_addr_q != 16'd7)) begin
                        out_data_d    = reg_rd_data_i;
                        out_kind_d    = KindReg;
                        out_addr_d    = 16'(reg_rd_addr_q);
                        reg_rd_addr_d = reg_rd_addr_q + 3'd1;
                    end else if (out_kind_q == KindReg) begin
                        // mem_rd_addr_q is still 0 from the trigger, so this reads word 0
                        mem_rd_en_o = 1'b1;
                        state_d     = StWait;
                    end else if (mem_rd_addr_q == LastAddr) begin
                        state_d = StDone;
                    end else begin
                        mem_rd_en_o   = 1'b1;
                        mem_rd_addr_d = mem_rd_addr_q + ADDR_W'(1);
                        state_d       = StWait;
                    end
                end
            end
            StWait: begin
                out_data_d = mem_rd_data_i;
                out_kind_d = KindMem;
                out_addr_d = 16'(mem_rd_addr_q);
                out_last_d = (mem_rd_addr_q == LastAddr);
                state_d    = StSend;
            end
            StDone: begin
                if (halt_q && !halt_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign reg_rd_addr_o = reg_rd_addr_q;
    assign mem_rd_addr_o = mem_rd_addr_q;
    assign out_valid_o   = (state_q == StSend);
    assign out_kind_o    = out_kind_q;
    assign out_addr_o    = out_addr_q;
    assign out_data_o    = out_data_q;
    assign out_last_o    = out_last_q;
    assign busy_o        = (state_q == StSend) || (state_q == StWait);
    assign done_o        = (state_q == StDone);

endmodule
